// File: rtl/sram_port_arbiter.sv
// Two-port round-robin front end for a single-port SRAM with a registered read.
// One command is serviced at a time: writes take one bus cycle, reads take a
// READ cycle (SRAM latches the word) and a CAPTURE cycle (SRAM drives the bus).
module sram_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_write,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [WIDTH-1:0]      p0_req_wdata,
  output logic                  p0_rsp_valid,
  output logic [WIDTH-1:0]      p0_rsp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_write,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [WIDTH-1:0]      p1_req_wdata,
  output logic                  p1_rsp_valid,
  output logic [WIDTH-1:0]      p1_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_address,
  inout  wire  [WIDTH-1:0]      sram_data,
  output logic                  sram_chip_select,
  output logic                  sram_write_enable,
  output logic                  sram_output_enable,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

  state_t                state, state_nxt;
  logic                  last_grant;   // port id of the most recently accepted command
  logic                  cmd_port;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [WIDTH-1:0]      cmd_wdata;
  logic                  grant0, grant1;
  logic                  accept;
  logic                  sel_write;
  logic                  bus_drive;

  // Round-robin choice: a lone requester wins, on contention the port that did not go last wins
  always_comb begin
    grant0 = p0_req_valid & (~p1_req_valid | last_grant);
    grant1 = p1_req_valid & (~p0_req_valid | ~last_grant);
  end

  assign p0_req_ready = (state == IDLE) & grant0;
  assign p1_req_ready = (state == IDLE) & grant1;
  assign accept       = p0_req_ready | p1_req_ready;
  assign sel_write    = p1_req_ready ? p1_req_write : p0_req_write;

  // State register plus the control side of the captured command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cmd_port   <= 1'b0;
      cmd_addr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= p1_req_ready;
        cmd_port   <= p1_req_ready;
        cmd_addr   <= p1_req_ready ? p1_req_addr : p0_req_addr;
      end
    end
  end

  // Write data is pure payload and only meaningful while WRITE follows an accept
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_wdata <= p1_req_ready ? p1_req_wdata : p0_req_wdata;
    end
  end

  // Next state and SRAM strobes; output_enable only in CAPTURE so the bus never has two drivers
  always_comb begin
    state_nxt          = state;
    sram_chip_select   = 1'b0;
    sram_write_enable  = 1'b0;
    sram_output_enable = 1'b0;
    bus_drive          = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = sel_write ? WRITE : READ;
      end
      WRITE: begin
        sram_chip_select  = 1'b1;
        sram_write_enable = 1'b1;
        bus_drive         = 1'b1;
        state_nxt         = IDLE;
      end
      READ: begin
        sram_chip_select = 1'b1;
        state_nxt        = CAPTURE;
      end
      CAPTURE: begin
        sram_chip_select   = 1'b1;
        sram_output_enable = 1'b1;
        state_nxt          = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sram_address = cmd_addr;
  assign sram_data    = bus_drive ? cmd_wdata : 'z;
  assign busy         = (state != IDLE);

  // Capture the SRAM word at the end of CAPTURE and pulse the owning port's valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_rdata <= '0;
    end else begin
      p0_rsp_valid <= (state == CAPTURE) & ~cmd_port;
      p1_rsp_valid <= (state == CAPTURE) & cmd_port;
      if ((state == CAPTURE) && !cmd_port) p0_rsp_rdata <= sram_data;
      if ((state == CAPTURE) && cmd_port)  p1_rsp_rdata <= sram_data;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM on the tristate bus, a memory
// array plus per-port expected-response queues as the reference, and a monitor
// that pops and compares whenever a port presents a response.
module tb_sram_port_arbiter;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          p0_req_valid, p0_req_ready, p0_req_write, p0_rsp_valid;
  logic [AW-1:0] p0_req_addr;
  logic [W-1:0]  p0_req_wdata, p0_rsp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_write, p1_rsp_valid;
  logic [AW-1:0] p1_req_addr;
  logic [W-1:0]  p1_req_wdata, p1_rsp_rdata;
  logic [AW-1:0] sram_address;
  wire  [W-1:0]  sram_data;
  logic          sram_chip_select, sram_write_enable, sram_output_enable, busy;

  sram_port_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .sram_address(sram_address), .sram_data(sram_data),
    .sram_chip_select(sram_chip_select), .sram_write_enable(sram_write_enable),
    .sram_output_enable(sram_output_enable), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM: registered read, drives bus only with oe and no we
  logic [W-1:0] sram_mem [D];
  logic [W-1:0] sram_q;
  always @(posedge clk) begin
    if (sram_chip_select) begin
      if (sram_write_enable) sram_mem[sram_address] <= sram_data;
      else                   sram_q <= sram_mem[sram_address];
    end
  end
  assign sram_data = (sram_chip_select && sram_output_enable && !sram_write_enable) ? sram_q : 'z;

  // Requester drive state, indexed by port
  logic          req_v [2];
  logic          req_w [2];
  logic [AW-1:0] req_a [2];
  logic [W-1:0]  req_d [2];
  assign p0_req_valid = req_v[0];
  assign p0_req_write = req_w[0];
  assign p0_req_addr  = req_a[0];
  assign p0_req_wdata = req_d[0];
  assign p1_req_valid = req_v[1];
  assign p1_req_write = req_w[1];
  assign p1_req_addr  = req_a[1];
  assign p1_req_wdata = req_d[1];

  logic [1:0] rdy;
  assign rdy = {p1_req_ready, p0_req_ready};

  // Reference model: memory contents, last winner, expected responses
  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;
  logic [W-1:0] ref_mem [D];
  int           model_last = 1;
  exp_t         q0 [$];
  exp_t         q1 [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic model_accept(int p);
    exp_t e;
    model_last = p;
    if (req_w[p]) begin
      ref_mem[req_a[p]] = req_d[p];
    end else begin
      e.data = ref_mem[req_a[p]];
      e.due  = cyc + 3;
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // One clock: check the grant against the round-robin rule, update the model, advance
  task automatic step(output int acc);
    logic [1:0] expg;
    acc = -1;
    #1;
    expg = 2'b00;
    if (req_v[0] && req_v[1]) expg = (model_last == 0) ? 2'b10 : 2'b01;
    else if (req_v[0])        expg = 2'b01;
    else if (req_v[1])        expg = 2'b10;
    if (rdy != 2'b00) begin
      chk("grant", 32'(rdy), 32'(expg));
      acc = rdy[1] ? 1 : 0;
      model_accept(acc);
    end
    @(posedge clk);
    @(negedge clk);
    if (acc >= 0) req_v[acc] = 1'b0;
  endtask

  task automatic idle(int n);
    int acc;
    repeat (n) step(acc);
  endtask

  task automatic issue(int p, bit wr, int addr, logic [W-1:0] data);
    int acc;
    int n;
    n = 0;
    req_v[p] = 1'b1;
    req_w[p] = wr;
    req_a[p] = AW'(addr);
    req_d[p] = data;
    do begin
      step(acc);
      n++;
    end while (acc != p && n < 20);
    if (acc != p) begin
      fail("accept_timeout");
      req_v[p] = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_ctl"}, {28'd0, sram_chip_select, sram_write_enable, sram_output_enable, busy}, 32'd0);
    chk({tag, "_rspv"}, {30'd0, p0_rsp_valid, p1_rsp_valid}, 32'd0);
    chk({tag, "_addr"}, 32'(sram_address), 32'd0);
    chk({tag, "_rdata0"}, p0_rsp_rdata, 32'd0);
    chk({tag, "_rdata1"}, p1_rsp_rdata, 32'd0);
  endtask

  // Response monitor and bus-contention watch
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (p0_rsp_valid) begin
        if (q0.size() == 0) fail("p0_unexpected_rsp");
        else begin
          e = q0.pop_front();
          chk("p0_rdata", p0_rsp_rdata, e.data);
          chk("p0_latency", cyc, e.due);
        end
      end else if (q0.size() > 0 && q0[0].due <= cyc) begin
        fail("p0_missing_rsp");
        void'(q0.pop_front());
      end
      if (p1_rsp_valid) begin
        if (q1.size() == 0) fail("p1_unexpected_rsp");
        else begin
          e = q1.pop_front();
          chk("p1_rdata", p1_rsp_rdata, e.data);
          chk("p1_latency", cyc, e.due);
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        fail("p1_missing_rsp");
        void'(q1.pop_front());
      end
      chk("bus_contention", {31'd0, sram_write_enable & sram_output_enable}, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int k;
    int n;
    for (int i = 0; i < D; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0;
      req_w[p] = 1'b0;
      req_a[p] = '0;
      req_d[p] = '0;
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // p0 writes 0xDEADBEEF to addr 3
    issue(0, 1'b1, 3, 32'hDEADBEEF);
    chk("write_ctl", {28'd0, sram_chip_select, sram_write_enable, sram_output_enable, busy}, 32'hD);
    chk("write_bus", sram_data, 32'hDEADBEEF);
    chk("write_addr", 32'(sram_address), 32'd3);
    idle(1);
    chk("write_busy_one_cycle", {31'd0, busy}, 32'd0);
    chk("mem3", sram_mem[3], 32'hDEADBEEF);

    // p1 reads it back
    issue(1, 1'b0, 3, '0);
    chk("read_ctl", {28'd0, sram_chip_select, sram_write_enable, sram_output_enable, busy}, 32'h9);
    idle(4);

    // Preload, then both ports hold reads: grants must alternate p0, p1, ...
    issue(0, 1'b1, 1, 32'h11);
    issue(1, 1'b1, 2, 32'h22);
    req_v[0] = 1'b1; req_w[0] = 1'b0; req_a[0] = 4'd1;
    req_v[1] = 1'b1; req_w[1] = 1'b0; req_a[1] = 4'd2;
    k = 0;
    n = 0;
    while (k < 6 && n < 40) begin
      step(acc);
      n++;
      if (acc >= 0) begin
        chk("alternate", 32'(acc), 32'(k % 2));
        k++;
        req_v[acc] = 1'b1;
      end
    end
    if (k < 6) fail("alternate_timeout");
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    idle(4);

    // Write then immediate read of the same address from the other port
    issue(0, 1'b1, 5, 32'hA5A50005);
    issue(1, 1'b0, 5, '0);
    idle(4);

    // Top address with all ones; address 0 left untouched
    issue(1, 1'b1, D - 1, 32'hFFFFFFFF);
    issue(0, 1'b0, D - 1, '0);
    issue(1, 1'b0, 0, '0);
    idle(4);

    // Reset asserted during CAPTURE abandons the read
    issue(0, 1'b0, 7, '0);
    idle(1);
    chk("capture_ctl", {28'd0, sram_chip_select, sram_write_enable, sram_output_enable, busy}, 32'hB);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    q0.delete();
    q1.delete();
    model_last = 1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_v[0] = 1'b1; req_w[0] = 1'b1; req_a[0] = 4'd8; req_d[0] = 32'h08080808;
    req_v[1] = 1'b1; req_w[1] = 1'b0; req_a[1] = 4'd9; req_d[1] = '0;
    step(acc);
    chk("post_reset_first_grant", 32'(acc), 32'd0);
    n = 0;
    do begin
      step(acc);
      n++;
    end while (acc != 1 && n < 10);
    if (acc != 1) fail("post_reset_p1_timeout");
    idle(4);

    // Random traffic on both ports
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_v[p] && $urandom_range(1, 0) == 1) begin
          req_v[p] = 1'b1;
          req_w[p] = 1'($urandom_range(1, 0));
          req_a[p] = AW'($urandom_range(D - 1, 0));
          req_d[p] = $urandom;
        end
      end
      step(acc);
    end
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    idle(6);
    chk("p0_queue_drained", 32'(q0.size()), 32'd0);
    chk("p1_queue_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-requester controller that sequences and shares one single_port_sram instance (WIDTH x DEPTH, tristate data bus).
- Each requester has a valid/ready command channel (read or write) and a read-response channel.
- Round-robin arbitration selects one requester at a time.
- An FSM generates chip_select, write_enable, output_enable, address and bus drive, and honours the SRAM's registered read (data on the bus one cycle after the read edge).

Parameters:
- WIDTH, 32, data width; must equal the SRAM WIDTH.
- DEPTH, 16, word count; must equal the SRAM DEPTH. Address width is localparam ADDR_WIDTH = $clog2(DEPTH).

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- p0_req_valid  input  1  port 0 command valid.
- p0_req_ready  output  1  port 0 command accepted this cycle.
- p0_req_write  input  1  1 = write, 0 = read.
- p0_req_addr  input  ADDR_WIDTH  port 0 address.
- p0_req_wdata  input  WIDTH  port 0 write data.
- p0_rsp_valid  output  1  one-cycle pulse: p0_rsp_rdata holds read result.
- p0_rsp_rdata  output  WIDTH  port 0 read data, registered, held until next p0 response.
- p1_* : same seven ports as p0_*, for port 1.
- sram_address  output  ADDR_WIDTH  to SRAM address.
- sram_data  inout  WIDTH  to SRAM data bus.
- sram_chip_select  output  1  to SRAM chip_select.
- sram_write_enable  output  1  to SRAM write_enable.
- sram_output_enable  output  1  to SRAM output_enable.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, last_grant=1 (so port 0 wins first contention).
  - All rsp_valid=0, all rsp_rdata=0.
  - sram_chip_select/write_enable/output_enable=0, sram_address=0, sram_data released (z).
  - Reset mid-operation abandons the in-flight command; no response is produced and no partial write is guaranteed.
- FSM states:
  - IDLE: accept a command.
  - WRITE: 1 cycle.
  - READ: 1 cycle.
  - CAPTURE: 1 cycle.
- Arbitration (IDLE only):
  - req_ready is combinational: px_req_ready = (state==IDLE) & px_req_valid & granted(x). Never asserted outside IDLE.
  - Only one port is valid: grant it.
  - Both valid: grant the port != last_grant.
  - last_grant updates only on an accepted command.
- Command capture: on an accept edge, register port id, write, addr and wdata. Next state is WRITE if write, else READ.
- WRITE:
  - cs=1, we=1, oe=0, sram_address=cmd_addr.
  - Controller drives sram_data=cmd_wdata. This is the only state in which the controller drives the bus; all other states release it to z.
  - SRAM updates at the closing edge. Next state IDLE. No response for writes.
- READ:
  - cs=1, we=0, oe=0, sram_address=cmd_addr.
  - SRAM latches the word at the closing edge. Next state CAPTURE.
- CAPTURE:
  - cs=1, we=0, oe=1, same address (the harmless re-read keeps the value identical).
  - At the closing edge, sram_data is registered into the granted port's rsp_rdata and that port's rsp_valid is set. Next state IDLE.
- rsp_valid:
  - High exactly the one cycle after CAPTURE, only on the requesting port.
  - A new command may be accepted in that same cycle.
- Timing:
  - Read: accepted at edge E0; response visible in the cycle after E2 (3 clocks issue-to-response). Throughput 1 read per 3 cycles.
  - Write: accepted at E0; memory updated at E1. Throughput 1 write per 2 cycles.
- Bus contention: output_enable is asserted only while we=0 and the controller is not driving. Controller drive and SRAM drive are never both active.
- Requesters must hold valid, write, addr and wdata stable until ready. The controller does not require this after acceptance.
- A back-to-back request from the same port while the other port is waiting loses to the other port (round-robin fairness).
- IDLE outputs: cs=0, we=0, oe=0. sram_address holds its last value.

Test Plan:
- Reset, then p0 writes 0xDEADBEEF to addr 3 → p0_req_ready high one cycle; WRITE cycle shows cs=1, we=1, sram_data=0xDEADBEEF; memory[3]=0xDEADBEEF; busy high 1 cycle.
- p1 reads addr 3 after that write → READ then CAPTURE; p1_rsp_valid pulses once, 3 cycles after accept; p1_rsp_rdata=0xDEADBEEF; p0_rsp_valid stays 0.
- Both ports hold valid reads continuously (p0 addr 1, p1 addr 2, preloaded 0x11 and 0x22) → grants alternate p0, p1, p0, p1; responses alternate 0x11/0x22; first grant goes to p0 after reset.
- Write to addr 5 immediately followed by a read of addr 5 from the other port → read returns the new value. Bench bus monitor sees no cycle with sram_data driven by both sides (no X).
- Assert rst_n low during a CAPTURE cycle → no rsp_valid; all outputs return to reset values asynchronously, before the next edge. After release, p0 wins the first contention.
- Wrap/boundary: write then read addr DEPTH-1 (15) with data 0xFFFFFFFF → read returns 0xFFFFFFFF. Addr 0 is unaffected.
